// File: rtl/instr_ctrl.sv
// instr_ctrl: consumes each loaded instruction and sequences
// the register-file, data-memory and ALU strobes for it.
module instr_ctrl #(
    parameter int RF_AW = 3,
    parameter int DM_AW = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ir_valid,
    input  logic [11:0]      ir,
    output logic             busy,
    output logic             done,
    output logic             pc_inc,
    output logic             illegal,
    output logic [RF_AW-1:0] rf_raddr1,
    output logic [RF_AW-1:0] rf_raddr2,
    output logic [RF_AW-1:0] rf_waddr,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             alu_op,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_we,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB,
        DONE
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;

    state_t      state;
    state_t      state_nx;
    logic [11:0] instr;
    logic [2:0]  op;
    logic        legal;

    assign op    = instr[11:9];
    assign legal = ~op[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr       <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && ir_valid)
                instr <= ir;
            if (state == DONE && legal)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Operand fields follow the latched copy, so they hold across IDLE.
    assign rf_raddr1 = (op == OP_STORE) ? RF_AW'(instr[8:6])
                                        : RF_AW'(instr[5:3]);
    assign rf_raddr2 = RF_AW'(instr[2:0]);
    assign rf_waddr  = RF_AW'(instr[8:6]);
    assign dm_addr   = DM_AW'(instr[3:0]);
    assign alu_op    = op[0];
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        pc_inc   = 1'b0;
        illegal  = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        dm_we    = 1'b0;
        case (state)
            IDLE: begin
                if (ir_valid)
                    state_nx = DECODE;
            end
            DECODE: begin
                state_nx = legal ? EXEC : DONE;
            end
            EXEC: begin
                if (op == OP_LOAD) begin
                    state_nx = MEM;
                end else if (op == OP_STORE) begin
                    dm_we    = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = WB;
                end
            end
            MEM: begin
                state_nx = WB;
            end
            WB: begin
                rf_we    = 1'b1;
                rf_wsel  = (op == OP_LOAD);
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                pc_inc   = legal;
                illegal  = ~legal;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/instr_ctrl.md
Name: instr_ctrl

Overview:
- Consumer side of the instruction register: accepts each freshly loaded 12-bit instruction and sequences the multi-cycle control strobes for register file, data memory and ALU.
- Signals completion back to the fetch side via pc_inc, which advances the instruction-memory address feeding the IR.
- Sits between the IR output and the datapath (register file, data memory, ALU) in the simple processor top level.

Parameters:
- RF_AW, 3, register-file address width (8 registers).
- DM_AW, 4, data-memory address width (16 words).
- CNT_W, 8, width of retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ir_valid  in  1  one-cycle pulse: IR output holds a newly loaded instruction
- ir  in  12  instruction from IR
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the instruction finishes
- pc_inc  out  1  one-cycle pulse, same cycle as done, legal instructions only
- illegal  out  1  one-cycle pulse, same cycle as done, for an undefined opcode
- rf_raddr1  out  RF_AW  register-file read port 1 address
- rf_raddr2  out  RF_AW  register-file read port 2 address
- rf_waddr  out  RF_AW  register-file write address
- rf_we  out  1  register-file write strobe
- rf_wsel  out  1  write-data select: 0 = ALU result, 1 = memory read data
- alu_op  out  1  0 = add, 1 = subtract
- dm_addr  out  DM_AW  data-memory address
- dm_we  out  1  data-memory write strobe
- instr_count  out  CNT_W  count of retired legal instructions

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high on rst.
- Reset state: FSM to IDLE, every output 0, instr_count 0, latched instruction 0.
- Reset mid-operation aborts immediately. No rf_we, dm_we, done or pc_inc is issued for the aborted instruction.
- Instruction fields, taken from the latched copy:
  - op = [11:9]
  - rd = [8:6]
  - ra = [5:3]
  - rb = [2:0]
  - maddr = [3:0]
- Opcodes:
  - 000 LOAD: RF[rd] <- DM[maddr]
  - 001 STORE: DM[maddr] <- RF[rd]
  - 010 ADD: RF[rd] <- RF[ra] + RF[rb]
  - 011 SUB: RF[rd] <- RF[ra] - RF[rb]
  - 100-111: illegal
- States: IDLE, DECODE, EXEC, MEM, WB, DONE.
- IDLE:
  - ir_valid=1 latches ir internally; next state DECODE.
  - The IR may change afterwards without affecting the operation.
- DECODE (1 cycle):
  - Legal op: next EXEC.
  - Illegal op: next DONE, with the illegal flag armed.
- EXEC:
  - ADD/SUB: next WB.
  - LOAD: next MEM.
  - STORE: dm_we=1 for exactly this cycle; next DONE.
- MEM (LOAD only): 1-cycle wait for the synchronous memory read; next WB.
- WB:
  - rf_we=1 for exactly this cycle; rf_waddr=rd.
  - rf_wsel=1 for LOAD, 0 for ADD/SUB.
  - Next DONE.
- DONE:
  - done=1.
  - Legal op: pc_inc=1 and instr_count increments. Counter wraps modulo 2^CNT_W.
  - Illegal op: illegal=1, and instr_count is unchanged.
  - Next IDLE.
- Address and operation outputs, driven from the latched instruction and stable from DECODE through DONE:
  - rf_raddr1 = ra for ADD/SUB, rd for STORE.
  - rf_raddr2 = rb.
  - dm_addr = maddr.
  - alu_op = op[0].
  - These outputs hold their values while in IDLE.
- Latency from the ir_valid cycle (t0):
  - ADD/SUB: rf_we at t3, done at t4.
  - LOAD: rf_we at t4, done at t5.
  - STORE: dm_we at t2, done at t3.
  - Illegal: done at t2.
- ir_valid is accepted only in IDLE. A pulse in DECODE, EXEC, MEM, WB or DONE is ignored and discarded, not queued.
- Strobe exclusivity: rf_we and dm_we are never both high, and each is never high for more than one cycle per instruction.

Test Plan:
- Reset, then ir_valid with ir=12'b010_001_010_011 (ADD r1,r2,r3):
  - rf_raddr1=2, rf_raddr2=3 and alu_op=0 from t1.
  - rf_we=1, rf_waddr=1, rf_wsel=0 at t3 only.
  - done=pc_inc=1 at t4; instr_count=1.
- ir=12'b000_101_00_1100 (LOAD r5,[12]):
  - dm_addr=12 from t1.
  - rf_we=1, rf_wsel=1, rf_waddr=5 at t4.
  - done at t5.
- ir=12'b001_011_00_0111 (STORE r3,[7]):
  - rf_raddr1=3, dm_addr=7.
  - dm_we=1 at t2 only, rf_we never asserted.
  - done at t3.
- ir=12'b110_000_000_000:
  - illegal=done=1 at t2, pc_inc=0.
  - No write strobes; instr_count unchanged.
- SUB accepted, then a second ir_valid at t2 with a different ir:
  - Ignored; the first instruction completes unchanged with alu_op=1.
  - busy falls after DONE; the next ir_valid in IDLE is accepted.
- rst asserted at t2 of a LOAD:
  - Next cycle: all outputs 0, state IDLE.
  - No rf_we or done afterwards.
- 256 back-to-back legal ADDs: instr_count wraps 255 -> 0.
